// File: rtl/poly_mm_sched.sv
// rtl/poly_mm_sched.sv - issue/drain sequencer for the pipelined Barrett multiplier
// Optional PMS_UNMASK_EN: write the recombined (share1 ^ share2) result instead of both shares.
module poly_mm_sched #(
  parameter int DW        = 24,
  parameter int AW        = 8,
  parameter int MM_LAT    = 4,
  parameter int DRAIN_MAX = 8
) (
  input  logic              poly_mm_clk,
  input  logic              poly_mm_rst_n,
  input  logic              pms_start,
  input  logic [AW:0]       pms_len,
  input  logic [AW-1:0]     pms_src_a_base,
  input  logic [AW-1:0]     pms_src_b_base,
  input  logic [AW-1:0]     pms_dst_base,
  input  logic [23:0]       pms_q,
  input  logic [24:0]       pms_m,
  input  logic [4:0]        pms_N,
  output logic              pms_busy,
  output logic              pms_done,
  output logic              pms_err,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr_a,
  output logic [AW-1:0]     rd_addr_b,
  input  logic [DW-1:0]     rd_data_a,
  input  logic [DW-1:0]     rd_data_b,
  output logic              mm_enable,
  output logic [DW-1:0]     mm_a,
  output logic [DW-1:0]     mm_b,
  output logic [23:0]       mm_q,
  output logic [24:0]       mm_m,
  output logic [4:0]        mm_N,
  output logic [1:0]        mm_compress,
  output logic [1:0]        mm_decompose,
  output logic [1:0]        mm_duv_mode,
  input  logic              mm_valid,
  input  logic [DW-1:0]     mm_share1,
  input  logic [DW-1:0]     mm_share2,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
`ifdef PMS_UNMASK_EN
  output logic [DW-1:0]     wr_data
`else
  output logic [2*DW-1:0]   wr_data
`endif
);

  // Drain counter must at least cover a normal drain of MM_LAT+1 cycles.
  localparam int DRAIN_CAP = (DRAIN_MAX > MM_LAT) ? DRAIN_MAX : MM_LAT + 1;
  localparam int DRAIN_W   = $clog2(DRAIN_CAP + 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [AW:0]          len_r, rd_idx, wr_cnt;
  logic [AW-1:0]        a_base_r, b_base_r, dst_base_r;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 mm_en_r, err_r, timeout;
  logic [23:0]          q_r;
  logic [24:0]          m_r;
  logic [4:0]           n_r;
  logic                 start_ok, wr_hit, wr_last;

  assign start_ok = (state == S_IDLE) && pms_start;
  assign wr_hit   = mm_valid && (state != S_IDLE) && (wr_cnt < len_r);
  assign wr_last  = wr_hit && ((wr_cnt + ONE) == len_r);

  always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n) begin
    if (!poly_mm_rst_n) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pms_busy = 1'b0;
    pms_done = 1'b0;
    rd_en    = 1'b0;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pms_start) state_nx = (pms_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        pms_busy = 1'b1;
        rd_en    = 1'b1;
        if (rd_idx == (len_r - ONE)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        pms_busy = 1'b1;
        // A completing write wins over a timeout landing on the same cycle.
        if (wr_last || (wr_cnt == len_r)) begin
          state_nx = S_DONE;
        end else if (drain_cnt == DRAIN_W'(DRAIN_MAX - 1)) begin
          timeout  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        pms_busy = 1'b1;
        pms_done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n) begin
    if (!poly_mm_rst_n) begin
      len_r      <= '0;
      rd_idx     <= '0;
      wr_cnt     <= '0;
      a_base_r   <= '0;
      b_base_r   <= '0;
      dst_base_r <= '0;
      drain_cnt  <= '0;
      mm_en_r    <= 1'b0;
      err_r      <= 1'b0;
      q_r        <= '0;
      m_r        <= '0;
      n_r        <= '0;
    end else begin
      mm_en_r <= rd_en;
      if (start_ok) begin
        len_r      <= pms_len;
        a_base_r   <= pms_src_a_base;
        b_base_r   <= pms_src_b_base;
        dst_base_r <= pms_dst_base;
        q_r        <= pms_q;
        m_r        <= pms_m;
        n_r        <= pms_N;
        rd_idx     <= '0;
        wr_cnt     <= '0;
        if (pms_len != '0) err_r <= 1'b0;
      end
      if (state == S_ISSUE) rd_idx <= rd_idx + ONE;
      if (wr_hit)           wr_cnt <= wr_cnt + ONE;
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                  drain_cnt <= '0;
      if (timeout)          err_r <= 1'b1;
    end
  end

  assign pms_err      = err_r;
  assign rd_addr_a    = rd_en ? (a_base_r + rd_idx[AW-1:0]) : '0;
  assign rd_addr_b    = rd_en ? (b_base_r + rd_idx[AW-1:0]) : '0;
  // Operands pass straight from RAM but read as zero whenever nothing is issued.
  assign mm_enable    = mm_en_r;
  assign mm_a         = mm_en_r ? rd_data_a : '0;
  assign mm_b         = mm_en_r ? rd_data_b : '0;
  assign mm_q         = q_r;
  assign mm_m         = m_r;
  assign mm_N         = n_r;
  assign mm_compress  = 2'b00;
  assign mm_decompose = 2'b00;
  assign mm_duv_mode  = 2'b00;
  assign wr_en        = wr_hit;
  assign wr_addr      = wr_hit ? (dst_base_r + wr_cnt[AW-1:0]) : '0;
`ifdef PMS_UNMASK_EN
  assign wr_data      = wr_hit ? (mm_share1 ^ mm_share2) : '0;
`else
  assign wr_data      = wr_hit ? {mm_share2, mm_share1} : '0;
`endif

endmodule
